// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// Define ALU_ARB_STATS_EN to add saturating grant/overflow counters.
module alu_share_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned FLAG_W = 3,
  parameter int unsigned TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [31:0]       req_instr0,
  input  logic [31:0]       req_instr1,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [DATA_W-1:0] req_b1,
  input  logic [TAG_W-1:0]  req_tag0,
  input  logic [TAG_W-1:0]  req_tag1,
  output logic [1:0]        resp_valid,
  input  logic [1:0]        resp_ready,
  output logic [DATA_W-1:0] resp_result,
  output logic [FLAG_W-1:0] resp_flags,
  output logic [TAG_W-1:0]  resp_tag,
  output logic [31:0]       alu_instr,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [FLAG_W-1:0] alu_flags,
  output logic              busy
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1,
  output logic [15:0]       ovf_cnt
`endif
);

  typedef enum logic {StIdle, StResp} state_e;

  state_e              state_q;
  logic                last_grant_q;
  logic                owner_q;
  logic [1:0]          resp_valid_q;
  logic [DATA_W-1:0]   result_q;
  logic [FLAG_W-1:0]   flags_q;
  logic [TAG_W-1:0]    tag_q;

  logic                winner;
  logic                accept;

  // A winner only exists in IDLE; its valid&ready handshake is the accept.
  always_comb begin
    accept    = (state_q == StIdle) && (|req_valid);
    winner    = (&req_valid) ? ~last_grant_q : req_valid[1];
    req_ready = 2'b00;
    alu_instr = '0;
    alu_a     = '0;
    alu_b     = '0;
    if (accept) begin
      req_ready[winner] = 1'b1;
      if (winner) begin
        alu_instr = req_instr1;
        alu_a     = req_a1;
        alu_b     = req_b1;
      end else begin
        alu_instr = req_instr0;
        alu_a     = req_a0;
        alu_b     = req_b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      resp_valid_q <= 2'b00;
      result_q     <= '0;
      flags_q      <= '0;
      tag_q        <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            state_q      <= StResp;
            owner_q      <= winner;
            last_grant_q <= winner;
            result_q     <= alu_result;
            flags_q      <= alu_flags;
            tag_q        <= winner ? req_tag1 : req_tag0;
            resp_valid_q <= winner ? 2'b10 : 2'b01;
          end
        end
        StResp: begin
          if (resp_ready[owner_q]) begin
            state_q      <= StIdle;
            resp_valid_q <= 2'b00;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_result = result_q;
  assign resp_flags  = flags_q;
  assign resp_tag    = tag_q;
  assign busy        = (state_q == StResp);

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
      ovf_cnt    <= '0;
    end else if (accept) begin
      if (!winner && grant_cnt0 != 16'hffff) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (winner && grant_cnt1 != 16'hffff)  grant_cnt1 <= grant_cnt1 + 16'd1;
      if (alu_flags[0] && ovf_cnt != 16'hffff) ovf_cnt <= ovf_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed table, corner sequences and a
// randomized run against a behavioural model. Stats checks compile under ALU_ARB_STATS_EN.
module tb_alu_share_arbiter;

  localparam logic [31:0] OP_ADD  = 32'd0;
  localparam logic [31:0] OP_SUB  = 32'd1;
  localparam logic [31:0] OP_ADDU = 32'd2;
  localparam logic [31:0] OP_SLT  = 32'd3;
  localparam logic [31:0] OP_BEQ  = 32'd4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = 2'b00, req_ready, resp_valid, resp_ready = 2'b00;
  logic [31:0] req_instr0 = '0, req_instr1 = '0, req_a0 = '0, req_a1 = '0;
  logic [31:0] req_b0 = '0, req_b1 = '0;
  logic [3:0]  req_tag0 = '0, req_tag1 = '0, resp_tag;
  logic [31:0] resp_result, alu_instr, alu_a, alu_b, alu_result;
  logic [2:0]  resp_flags, alu_flags;
  logic        busy;
`ifdef ALU_ARB_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1, ovf_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_share_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_instr0(req_instr0), .req_instr1(req_instr1), .req_a0(req_a0), .req_a1(req_a1),
    .req_b0(req_b0), .req_b1(req_b1), .req_tag0(req_tag0), .req_tag1(req_tag1),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .resp_flags(resp_flags), .resp_tag(resp_tag), .alu_instr(alu_instr), .alu_a(alu_a),
    .alu_b(alu_b), .alu_result(alu_result), .alu_flags(alu_flags), .busy(busy)
`ifdef ALU_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .ovf_cnt(ovf_cnt)
`endif
  );

  // Reference ALU: {zero, lt, ovf, result}
  function automatic logic [34:0] alu_fn(input logic [31:0] ins, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    logic lt, ov;
    r = '0; lt = 1'b0; ov = 1'b0;
    case (ins)
      OP_ADD:  begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
      OP_SUB:  begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
      OP_ADDU: r = a + b;
      OP_SLT:  begin lt = ($signed(a) < $signed(b)); r = {31'd0, lt}; end
      OP_BEQ:  r = a - b;
      default: r = '0;
    endcase
    return {(r == 32'd0), lt, ov, r};
  endfunction

  always_comb {alu_flags, alu_result} = alu_fn(alu_instr, alu_a, alu_b);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 2'b00;
    resp_ready = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic set_port(input int p, input logic [31:0] ins, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] tag);
    if (p == 0) begin
      req_instr0 = ins; req_a0 = a; req_b0 = b; req_tag0 = tag; req_valid[0] = 1'b1;
    end else begin
      req_instr1 = ins; req_a1 = a; req_b1 = b; req_tag1 = tag; req_valid[1] = 1'b1;
    end
  endtask

  typedef struct {
    int          port;
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] res;
    logic [2:0]  flg;
  } vec_t;

  vec_t tbl[5];

  // Behavioural model state for the randomized phase
  bit          m_busy, m_last, m_owner;
  logic [31:0] m_res;
  logic [2:0]  m_flg;
  logic [3:0]  m_tag;
  int          m_g0, m_g1, m_ovf;
  bit          pv[2];
  logic [31:0] pin[2], pa[2], pb[2];
  logic [3:0]  pt[2];

  initial begin
    tbl[0] = '{0, OP_ADD,  32'h80000001, 32'h80000001, 4'd1, 32'h00000002, 3'b001};
    tbl[1] = '{1, OP_SUB,  32'hfffffffe, 32'h00000002, 4'd5, 32'hfffffffc, 3'b000};
    tbl[2] = '{0, OP_BEQ,  32'h00000002, 32'h00000002, 4'd3, 32'h00000000, 3'b100};
    tbl[3] = '{1, OP_SLT,  32'hfffffffb, 32'hffffffff, 4'd7, 32'h00000001, 3'b010};
    tbl[4] = '{0, OP_ADDU, 32'h00000007, 32'h00000008, 4'd9, 32'h0000000f, 3'b000};

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_result", 64'(resp_result), 64'd0);
    chk("rst_flags", 64'(resp_flags), 64'd0);
    chk("rst_tag", 64'(resp_tag), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_alu_a", 64'(alu_a), 64'd0);

    // Port 0 only add with signed overflow
    tick();
    set_port(0, OP_ADD, 32'h7ffffffe, 32'h00000002, 4'd2);
    @(negedge clk);
    chk("p0_req_ready", 64'(req_ready), 64'b01);
    chk("p0_alu_a", 64'(alu_a), 64'h7ffffffe);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    chk("p0_resp_valid", 64'(resp_valid), 64'b01);
    chk("p0_result", 64'(resp_result), 64'h80000000);
    chk("p0_flags", 64'(resp_flags), 64'b001);
    chk("p0_tag", 64'(resp_tag), 64'd2);
    resp_ready = 2'b01;
    tick();
    resp_ready = 2'b00;

    // Table of single-port ops
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_port(tbl[i].port, tbl[i].instr, tbl[i].a, tbl[i].b, tbl[i].tag);
      @(negedge clk);
      chk("tbl_req_ready", 64'(req_ready), 64'(2'b01 << tbl[i].port));
      chk("tbl_alu_instr", 64'(alu_instr), 64'(tbl[i].instr));
      tick();
      req_valid = 2'b00;
      @(negedge clk);
      chk("tbl_resp_valid", 64'(resp_valid), 64'(2'b01 << tbl[i].port));
      chk("tbl_result", 64'(resp_result), 64'(tbl[i].res));
      chk("tbl_flags", 64'(resp_flags), 64'(tbl[i].flg));
      chk("tbl_tag", 64'(resp_tag), 64'(tbl[i].tag));
      resp_ready = 2'b11;
      tick();
      resp_ready = 2'b00;
    end
`ifdef ALU_ARB_STATS_EN
    chk("stat_grant0", 64'(grant_cnt0), 64'd3);
    chk("stat_grant1", 64'(grant_cnt1), 64'd2);
    chk("stat_ovf", 64'(ovf_cnt), 64'd1);
`endif

    // Contention after reset: port 0 first, then port 1
    do_reset();
    set_port(0, OP_BEQ, 32'd2, 32'd2, 4'd3);
    set_port(1, OP_SUB, 32'hfffffffe, 32'd2, 4'd5);
    @(negedge clk);
    chk("both_req_ready", 64'(req_ready), 64'b01);
    chk("both_alu_instr", 64'(alu_instr), 64'(OP_BEQ));
    tick();
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("both_rv0", 64'(resp_valid), 64'b01);
    chk("both_res0", 64'(resp_result), 64'd0);
    chk("both_flg0", 64'(resp_flags), 64'b100);
    chk("both_tag0", 64'(resp_tag), 64'd3);
    chk("both_ready_resp", 64'(req_ready), 64'b00);
    resp_ready = 2'b01;
    tick();
    @(negedge clk);
    chk("both_gap_rv", 64'(resp_valid), 64'b00);
    chk("both_gap_ready", 64'(req_ready), 64'b10);
    tick();
    req_valid[1] = 1'b0;
    @(negedge clk);
    chk("both_rv1", 64'(resp_valid), 64'b10);
    chk("both_res1", 64'(resp_result), 64'hfffffffc);
    chk("both_flg1", 64'(resp_flags), 64'b000);
    chk("both_tag1", 64'(resp_tag), 64'd5);
    resp_ready = 2'b10;
    tick();

    // Backpressure: port 0 owns, port 1 waits
    resp_ready = 2'b00;
    set_port(0, OP_ADD, 32'd1, 32'd2, 4'd2);
    set_port(1, OP_ADDU, 32'd7, 32'd8, 4'd6);
    @(negedge clk);
    chk("bp_req_ready", 64'(req_ready), 64'b01);
    tick();
    req_valid[0] = 1'b0;
    resp_ready = 2'b10;  // non-owner ready must be ignored
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_rv", 64'(resp_valid), 64'b01);
      chk("bp_result", 64'(resp_result), 64'd3);
      chk("bp_tag", 64'(resp_tag), 64'd2);
      chk("bp_busy", 64'(busy), 64'd1);
      chk("bp_req_ready", 64'(req_ready), 64'b00);
      chk("bp_alu_a", 64'(alu_a), 64'd0);
      tick();
    end
    resp_ready = 2'b01;
    tick();
    @(negedge clk);
    chk("bp_idle_busy", 64'(busy), 64'd0);
    chk("bp_grant1", 64'(req_ready), 64'b10);
    tick();
    req_valid[1] = 1'b0;
    @(negedge clk);
    chk("bp_rv1", 64'(resp_valid), 64'b10);
    chk("bp_res1", 64'(resp_result), 64'd15);
    resp_ready = 2'b11;
    tick();

    // Both ports continuously valid: strict alternation, one op per two cycles
    do_reset();
    set_port(0, OP_ADDU, 32'd7, 32'd8, 4'd0);
    set_port(1, OP_ADDU, 32'd7, 32'd8, 4'd1);
    resp_ready = 2'b11;
    begin
      int ngrant = 0;
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        chk("alt_grant_slot", 64'(req_ready != 2'b00), 64'(c % 2 == 0));
        if (req_ready != 2'b00) begin
          chk("alt_order", 64'(req_ready), 64'(2'b01 << (ngrant % 2)));
          ngrant++;
        end else begin
          chk("alt_result", 64'(resp_result), 64'd15);
          chk("alt_tag", 64'(resp_tag), 64'((ngrant - 1) % 2));
        end
        tick();
      end
      chk("alt_count", 64'(ngrant), 64'd8);
    end

    // Reset while holding a response
    do_reset();
    set_port(1, OP_SLT, 32'hfffffffb, 32'hffffffff, 4'd4);
    @(negedge clk);
    chk("mid_req_ready", 64'(req_ready), 64'b10);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    chk("mid_rv", 64'(resp_valid), 64'b10);
    chk("mid_flags", 64'(resp_flags), 64'b010);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_async_drop", 64'(resp_valid), 64'b00);
    @(posedge clk);
    #2 rst_n = 1'b1;
    set_port(0, OP_ADDU, 32'd1, 32'd1, 4'd8);
    set_port(1, OP_ADDU, 32'd2, 32'd2, 4'd9);
    @(negedge clk);
    chk("mid_no_resp", 64'(resp_valid), 64'b00);
    chk("mid_next_p0", 64'(req_ready), 64'b01);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    chk("mid_new_rv", 64'(resp_valid), 64'b01);
    chk("mid_new_tag", 64'(resp_tag), 64'd8);
    resp_ready = 2'b11;
    tick();

    // Randomized run against the behavioural model
    do_reset();
    m_busy = 0; m_last = 1; m_owner = 0; m_res = '0; m_flg = '0; m_tag = '0;
    m_g0 = 0; m_g1 = 0; m_ovf = 0;
    pv[0] = 0; pv[1] = 0;
    for (int c = 0; c < 600; c++) begin
      bit hold, w;
      for (int p = 0; p < 2; p++) begin
        if (pv[p] && ($urandom_range(0, 7) != 0)) begin
          hold = 1;
        end else begin
          hold = 0;
          pv[p]  = ($urandom_range(0, 1) == 1);
          pin[p] = 32'($urandom_range(0, 4));
          pa[p]  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
          pb[p]  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
          pt[p]  = 4'($urandom);
        end
        if (!hold && pv[p]) set_port(p, pin[p], pa[p], pb[p], pt[p]);
        else if (!pv[p]) req_valid[p] = 1'b0;
      end
      resp_ready = 2'($urandom);
      @(negedge clk);
      w = (pv[0] && pv[1]) ? !m_last : pv[1];
      if (m_busy) begin
        chk("rnd_rv", 64'(resp_valid), 64'(2'b01 << m_owner));
        chk("rnd_result", 64'(resp_result), 64'(m_res));
        chk("rnd_flags", 64'(resp_flags), 64'(m_flg));
        chk("rnd_tag", 64'(resp_tag), 64'(m_tag));
        chk("rnd_ready_busy", 64'(req_ready), 64'd0);
        chk("rnd_busy", 64'(busy), 64'd1);
      end else begin
        chk("rnd_rv_idle", 64'(resp_valid), 64'd0);
        chk("rnd_busy_idle", 64'(busy), 64'd0);
        if (pv[0] || pv[1]) begin
          chk("rnd_ready", 64'(req_ready), 64'(2'b01 << w));
          chk("rnd_alu_a", 64'(alu_a), 64'(pa[w]));
          chk("rnd_alu_b", 64'(alu_b), 64'(pb[w]));
        end else begin
          chk("rnd_ready_none", 64'(req_ready), 64'd0);
          chk("rnd_alu_zero", 64'(alu_instr), 64'd0);
        end
      end
      if (!m_busy && (pv[0] || pv[1])) begin
        logic [34:0] r;
        r = alu_fn(pin[w], pa[w], pb[w]);
        m_res = r[31:0]; m_flg = r[34:32]; m_tag = pt[w];
        m_busy = 1; m_owner = w; m_last = w;
        if (w) m_g1++; else m_g0++;
        if (r[32]) m_ovf++;
        pv[w] = 0;  // accepted; a fresh request may follow
      end else if (m_busy && resp_ready[m_owner]) begin
        m_busy = 0;
      end
      tick();
    end
`ifdef ALU_ARB_STATS_EN
    chk("rnd_grant0", 64'(grant_cnt0), 64'(m_g0));
    chk("rnd_grant1", 64'(grant_cnt1), 64'(m_g1));
    chk("rnd_ovf", 64'(ovf_cnt), 64'(m_ovf));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU (instruction, regA, regB -> result, flags[2:0]) between two requesters, e.g. the EX stage and a multi-cycle helper unit.
- Each requester gets a valid/ready request channel and a valid/ready response channel.
- Round-robin arbitration, one operation in flight, result and flags registered.
- Sits beside the ALU instance in the execute stage; the ALU is instantiated outside and connected through the alu_* ports.

Parameters:
- DATA_W, 32, operand/result width
- FLAG_W, 3, ALU flags width; bit2 = zero/equal, bit1 = less-than, bit0 = overflow
- TAG_W, 4, requester-supplied tag, returned unchanged with the result

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  per-port request valid
- req_ready  out  2  per-port request accept
- req_instr0, req_instr1  in  32 each  instruction word per port
- req_a0, req_a1, req_b0, req_b1  in  DATA_W each  operands per port
- req_tag0, req_tag1  in  TAG_W each  tag per port
- resp_valid  out  2  per-port response valid
- resp_ready  in  2  per-port response accept
- resp_result  out  DATA_W  registered ALU result
- resp_flags  out  FLAG_W  registered ALU flags
- resp_tag  out  TAG_W  tag of the completed operation
- alu_instr  out  32  to ALU instruction input
- alu_a, alu_b  out  DATA_W each  to ALU regA/regB
- alu_result  in  DATA_W  from ALU
- alu_flags  in  FLAG_W  from ALU
- busy  out  1  high in RESP state

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, resp_valid=0, resp_result/flags/tag=0.
  - last_grant=1, so port 0 wins the first contention.
- FSM has two states, IDLE and RESP.
- IDLE, winner selection:
  - Only port i valid -> winner i.
  - Both valid -> winner = port != last_grant.
  - Neither valid -> no winner; alu_* driven to 0.
- IDLE, handshake:
  - req_ready is combinational: 1 only for the winner, 0 for the loser.
  - On the winner's valid & ready, alu_* are driven from the winner's fields in the same cycle.
  - At that clock edge: alu_result/alu_flags/tag captured, owner=winner, last_grant=winner, state->RESP.
- RESP:
  - resp_valid[owner]=1 and resp_valid[other]=0; outputs held stable.
  - req_ready=00; alu_* driven to 0.
  - On resp_ready[owner]=1 -> IDLE and resp_valid clears at that edge. resp_ready of the non-owner is ignored.
- Latency and throughput:
  - Request accept at edge N -> resp_valid visible after edge N.
  - Minimum 2 cycles per op (mandatory IDLE cycle between ops).
  - Two continuously valid ports alternate strictly 0,1,0,1.
- Requester rules:
  - A requester holds instr/a/b/tag stable while valid && !ready.
  - The arbiter does not re-sample a loser's fields.
  - Dropping valid before grant is legal and causes no grant.
- Flags and result pass through bit-exact, no width change: overflow reported by the ALU for add/sub/addi is returned unchanged, as is the zero flag for beq/bne.
- Reset mid-op (in RESP or during accept) discards the operation; no response is ever issued for it.

Optional Feature:
- Macro ALU_ARB_STATS_EN.
- Defined:
  - Adds outputs grant_cnt0, grant_cnt1 (16 b each) and ovf_cnt (16 b), all reset to 0.
  - grant_cntN increments on each accepted request from port N.
  - ovf_cnt increments when a captured result has flags[0]=1.
  - All three saturate at 0xFFFF.
- Undefined: those ports and registers do not exist; behaviour otherwise identical.

Test Plan:
- Reset release, port 0 only: add, a=0x7ffffffe, b=0x00000002.
  - Expect req_ready=01 same cycle.
  - Next cycle resp_valid=01, resp_result=0x80000000, resp_flags=001.
- Both valid in the same cycle after reset:
  - Port 0 beq 2,2, tag 3; port 1 sub -2,2, tag 5.
  - Port 0 served first: result 0, flags 100, tag 3.
  - After the IDLE gap, port 1: result 0xfffffffc, flags 000, tag 5.
- Backpressure: hold resp_ready=0 for 5 cycles.
  - resp_* stay stable and busy=1.
  - req_ready=00 even with port 1 valid.
  - Release -> next IDLE cycle grants port 1.
- Both ports continuously valid for 8 ops (addu 7+8): grant order 0,1,0,1,0,1,0,1, each result 15, one op per 2 cycles.
- Assert rst_n=0 while in RESP holding slt -5,-1.
  - resp_valid drops to 00 asynchronously.
  - After release no response for that op; the next grant goes to port 0.
- With ALU_ARB_STATS_EN: 3 port-0 ops, including one add 0x80000001+0x80000001 (flags 001), plus 2 port-1 ops.
  - Expect grant_cnt0=3, grant_cnt1=2, ovf_cnt=1.
